d_sramlike_bridge: RTL and testbench

Sits between the CPU datapath's memory-stage data port and the SRAM-like data bus toward the cache/AXI crossbar. It converts each single-cycle memory-stage access into a bus transaction with an address phase and a data phase. It raises d_stall while the access is outstanding. It holds the result until the whole pipeline releases (longest_stall low), so the same access is never issued twice.

---
 rtl/d_sramlike_bridge.sv | 104 ++++++++++
 tb/tb_d_sramlike_bridge.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/d_sramlike_bridge.sv
// d_sramlike_bridge: memory-stage data port to SRAM-like bus bridge with a watchdog.
// Define D_BRIDGE_RDATA_BYPASS_EN to forward bus rdata and release d_stall on the data_ok cycle.
module d_sramlike_bridge #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wenM,
    input  logic [31:0] data_sram_waddr,
    input  logic [31:0] data_sram_wdataM,
    input  logic        longest_stall,
    output logic [31:0] data_sram_rdataM,
    output logic        d_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} stateT;
    localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYC);

    stateT       state, nextState;
    logic [3:0]  wenQ;
    logic [1:0]  sizeQ, sizeD, addrLo;
    logic [31:0] addrQ, wdataQ, rdataQ, wdCnt;
    logic        busy, dataHit, capture, expire, busErr;

    always_comb begin
        busy = (state == ADDR) || (state == DATA);
        dataHit = (state == DATA) && data_data_ok;
        capture = dataHit || ((state == ADDR) && data_addr_ok && data_data_ok);
        expire = busy && !capture && (TIMEOUT != 32'd0) && (wdCnt + 32'd1 >= TIMEOUT);
        nextState = state;
        case (state)
            IDLE:    nextState = data_sram_en ? ADDR : IDLE;
            ADDR:    nextState = (capture || expire) ? DONE : data_addr_ok ? DATA : ADDR;
            DATA:    nextState = (capture || expire) ? DONE : DATA;
            default: nextState = longest_stall ? DONE : IDLE;
        endcase
    end

    // Bus size and low address bits are decided once, when the request is latched
    always_comb begin
        sizeD = 2'd2;
        addrLo = 2'd0;
        case (data_sram_wenM)
            4'b0001: begin sizeD = 2'd0; addrLo = 2'd0; end
            4'b0010: begin sizeD = 2'd0; addrLo = 2'd1; end
            4'b0100: begin sizeD = 2'd0; addrLo = 2'd2; end
            4'b1000: begin sizeD = 2'd0; addrLo = 2'd3; end
            4'b0011: begin sizeD = 2'd1; addrLo = 2'd0; end
            4'b1100: begin sizeD = 2'd1; addrLo = 2'd2; end
            default: begin sizeD = 2'd2; addrLo = 2'd0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            wenQ   <= '0;
            sizeQ  <= '0;
            addrQ  <= '0;
            wdataQ <= '0;
            rdataQ <= '0;
            wdCnt  <= '0;
            busErr <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && data_sram_en) begin
                wenQ   <= data_sram_wenM;
                sizeQ  <= sizeD;
                addrQ  <= {data_sram_waddr[31:2], addrLo};
                wdataQ <= data_sram_wdataM;
            end
            if (capture)
                rdataQ <= data_rdata;
            else if (expire)
                rdataQ <= '0;
            wdCnt  <= busy ? wdCnt + 32'd1 : '0;
            busErr <= busErr | expire;
        end
    end

    assign data_req   = (state == ADDR);
    assign data_wr    = |wenQ;
    assign data_size  = sizeQ;
    assign data_addr  = addrQ;
    assign data_wdata = wdataQ;
    assign bus_err    = busErr;

`ifdef D_BRIDGE_RDATA_BYPASS_EN
    assign data_sram_rdataM = dataHit ? data_rdata : rdataQ;
    assign d_stall = (state == IDLE) ? data_sram_en : (busy && !dataHit);
`else
    assign data_sram_rdataM = rdataQ;
    assign d_stall = (state == IDLE) ? data_sram_en : busy;
`endif
endmodule

// File: tb/tb_d_sramlike_bridge.sv
// tb_d_sramlike_bridge: directed and randomized accesses checked against a transaction-level model.
module tb_d_sramlike_bridge;
`ifdef D_BRIDGE_RDATA_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, tbStall = 1'b0, addrOk = 1'b0, dataOk = 1'b0;
    logic [3:0]  wen = '0;
    logic [31:0] waddr = '0, wdataM = '0, busRdata = '0;
    logic [31:0] rdataM, dataAddr, dataWdata;
    logic [1:0]  dataSize;
    logic        dStall, dataReq, dataWr, busErr, longestStall;
    int          compared = 0, mismatched = 0, reqRises = 0, reqCycles = 0;
    logic        reqPrev = 1'b0;
    logic [31:0] lastR = '0;

    assign longestStall = tbStall | dStall;
    always #5 clk = ~clk;

    d_sramlike_bridge #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wenM(wen),
        .data_sram_waddr(waddr), .data_sram_wdataM(wdataM), .longest_stall(longestStall),
        .data_sram_rdataM(rdataM), .d_stall(dStall), .data_req(dataReq), .data_wr(dataWr),
        .data_size(dataSize), .data_addr(dataAddr), .data_wdata(dataWdata),
        .data_rdata(busRdata), .data_addr_ok(addrOk), .data_data_ok(dataOk), .bus_err(busErr)
    );

    always @(posedge clk) begin
        reqPrev <= dataReq;
        if (dataReq && !reqPrev) reqRises++;
        if (dataReq) reqCycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: one set bit -> byte at that lane; aligned pair -> half; everything else -> word at offset 0
    function automatic logic [1:0] expSize(input logic [3:0] w);
        if ($countones(w) == 1) return 2'd0;
        if (w == 4'b0011 || w == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] expAddr(input logic [3:0] w, input logic [31:0] a);
        int lo = 0;
        if (expSize(w) != 2'd2)
            for (int i = 3; i >= 0; i--) if (w[i]) lo = i;
        return {a[31:2], 2'(lo)};
    endfunction

    task automatic busOut(input string tag, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_wr"}, dataWr, {31'd0, w != 4'd0});
        chk({tag, "_size"}, dataSize, expSize(w));
        chk({tag, "_addr"}, dataAddr, expAddr(w, a));
        chk({tag, "_wdata"}, dataWdata, d);
    endtask

    task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] r, input int aDly, input int dDly, input bit same, input int hold);
        int r0 = reqRises, c0 = reqCycles;
        en = 1'b1; wen = w; waddr = a; wdataM = d; tbStall = 1'b0;
        #1 chk("idle_stall", dStall, 1);
        chk("idle_req", dataReq, 0);
        @(negedge clk);
        for (int c = 0; c <= aDly; c++) begin
            addrOk = (c == aDly);
            dataOk = same && (c == aDly);
            busRdata = dataOk ? r : $urandom;
            #1 chk("addr_req", dataReq, 1);
            chk("addr_stall", dStall, 1);
            chk("addr_rdata", rdataM, lastR);
            busOut("addr", w, a, d);
            @(negedge clk);
        end
        addrOk = 1'b0; dataOk = 1'b0;
        if (!same)
            for (int c = 0; c <= dDly; c++) begin
                dataOk = (c == dDly);
                busRdata = dataOk ? r : $urandom;
                #1 chk("data_req", dataReq, 0);
                chk("data_stall", dStall, {31'd0, !(BYP && dataOk)});
                chk("data_rdata", rdataM, (BYP && dataOk) ? r : lastR);
                busOut("data", w, a, d);
                @(negedge clk);
            end
        dataOk = 1'b0;
        busRdata = $urandom;
        lastR = r;
        for (int h = 0; h <= hold; h++) begin
            tbStall = (h < hold);
            #1 chk("done_stall", dStall, 0);
            chk("done_req", dataReq, 0);
            chk("done_rdata", rdataM, lastR);
            @(negedge clk);
        end
        en = 1'b0;
        #1 chk("back_idle_stall", dStall, 0);
        chk("held_rdata", rdataM, lastR);
        chk("req_txns", reqRises - r0, 1);
        chk("req_cycles", reqCycles - c0, aDly + 1);
    endtask

    initial begin
        logic [3:0] pats [10];
        pats = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0110, 4'b1011};
        repeat (2) @(negedge clk);
        #1 chk("rst_stall", dStall, 0);
        chk("rst_req", dataReq, 0);
        chk("rst_wr", dataWr, 0);
        chk("rst_size", dataSize, 0);
        chk("rst_addr", dataAddr, 0);
        chk("rst_wdata", dataWdata, 0);
        chk("rst_rdata", rdataM, 0);
        chk("rst_err", busErr, 0);
        rst = 1'b1;
        @(negedge clk);
        access(4'b0000, 32'h0000_1004, 32'h5555_AAAA, 32'hDEAD_BEEF, 1, 1, 1'b0, 0);
        access(4'b0100, 32'h0000_2000, 32'h00AB_0000, 32'h0BAD_F00D, 0, 0, 1'b0, 0);
        access(4'b1100, 32'h0000_3001, 32'hBEEF_0000, 32'h1111_2222, 0, 1, 1'b0, 1);
        access(4'b1111, 32'h0000_4003, 32'hCAFE_BABE, 32'h3333_4444, 2, 0, 1'b0, 0);
        access(4'b0000, 32'h0000_5008, 32'h0, 32'h5A5A_A5A5, 0, 2, 1'b0, 5);
        access(4'b0000, 32'h0000_6000, 32'h0, 32'h1234_5678, 2, 0, 1'b1, 0);
        for (int k = 0; k < 24; k++)
            access(pats[$urandom_range(9, 0)], $urandom, $urandom, $urandom,
                   $urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(3, 0) == 0, $urandom_range(3, 0));
        en = 1'b1; wen = 4'b0000; waddr = 32'h0000_7000; tbStall = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            #1 chk("wd_req", dataReq, 1);
            chk("wd_err_pre", busErr, 0);
            @(negedge clk);
        end
        #1 chk("wd_err", busErr, 1);
        chk("wd_stall", dStall, 0);
        chk("wd_rdata", rdataM, 0);
        chk("wd_req_done", dataReq, 0);
        tbStall = 1'b0;
        lastR = '0;
        @(negedge clk);
        en = 1'b0;
        #1 chk("wd_err_sticky", busErr, 1);
        chk("wd_idle_stall", dStall, 0);
        en = 1'b1; wen = 4'b1111; waddr = 32'h0000_8000; wdataM = 32'h7777_8888;
        @(negedge clk);
        addrOk = 1'b1;
        @(negedge clk);
        addrOk = 1'b0;
        #1 chk("mid_data_req", dataReq, 0);
        chk("mid_data_stall", dStall, 1);
        rst = 1'b0; en = 1'b0;
        #1 chk("arst_req", dataReq, 0);
        chk("arst_stall", dStall, 0);
        chk("arst_err", busErr, 0);
        chk("arst_addr", dataAddr, 0);
        chk("arst_wdata", dataWdata, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        access(4'b0001, 32'h0000_9003, 32'h0000_00EE, 32'hFEED_FACE, 1, 0, 1'b0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
